vex_bram_bus_arbiter: RTL and testbench
=======================================

// Module: vex_bram_bus_arbiter
// PURPOSE
//  Upstream feeder for the on-chip BRAM (10-bit word address, 32-bit data, byteenable, chipselect/clken).
//  Arbitrates VexRiscv iBus (fetch) and dBus (load/store) simple-bus commands onto the single BRAM port.
//  Generates byte enables from access size and address, and rejects out-of-range or misaligned accesses.
//  Tracks BRAM read latency and returns read data to the originating bus with an error flag.
// PARAMETERS
//  ADDR_W         10            BRAM word-address width; BRAM window = 4*2^ADDR_W bytes
//  BASE_ADDR      32'h0000_0000 byte base of the BRAM window; must be window-size aligned
//  READ_LATENCY   1             BRAM readdata delay after the accept cycle; legal values 1 or 2
//  STARVE_LIMIT   2             consecutive iBus losses before iBus is forced a grant; range 1..7
// PORTS
//  clk_clk                   in   1       single clock domain
//  reset_reset_n             in   1       asynchronous assert, active-low reset
//  ibus_cmd_valid            in   1       fetch request
//  ibus_cmd_ready            out  1       fetch accepted this cycle
//  ibus_cmd_pc               in   32      fetch byte address
//  ibus_rsp_valid            out  1       fetch response
//  ibus_rsp_error            out  1       fetch was out of range or misaligned
//  ibus_rsp_inst             out  32      fetched word; 0 when error
//  dbus_cmd_valid            in   1       load/store request
//  dbus_cmd_ready            out  1       load/store accepted this cycle
//  dbus_cmd_wr               in   1       1 = store, 0 = load
//  dbus_cmd_address          in   32      byte address
//  dbus_cmd_data             in   32      store data, already lane-replicated by the CPU
//  dbus_cmd_size             in   2       0 = byte, 1 = half, 2 = word (3 is illegal and raises an error)
//  dbus_rsp_valid            out  1       load response; stores give no response
//  dbus_rsp_error            out  1       load was rejected
//  dbus_rsp_data             out  32      load word; 0 when error
//  onchip_memory_address     out  ADDR_W  word address = (addr - BASE_ADDR) >> 2
//  onchip_memory_chipselect  out  1       high only for a legal accepted access
//  onchip_memory_clken       out  1       constant 1 out of reset
//  onchip_memory_write       out  1       high for a legal accepted store
//  onchip_memory_writedata   out  32      dbus_cmd_data pass-through
//  onchip_memory_byteenable  out  4       lane mask
//  onchip_memory_readdata    in   32      BRAM read data
//  err_sticky                out  1       set by any rejected access (including stores); cleared only by reset
// BEHAVIOUR
//  Reset: all rsp_valid/error/data outputs = 0; chipselect = 0, write = 0, byteenable = 0; starve counter = 0;
//   response pipeline is flushed. A reset asserted mid-operation drops in-flight reads; no response is issued.
//  Arbitration (combinational grant, at most one accept per cycle):
//   - dBus has priority.
//   - If ibus_cmd_valid is high and dBus wins, starve_cnt increments.
//   - When starve_cnt == STARVE_LIMIT and ibus_cmd_valid is high, iBus is granted and starve_cnt clears.
//   - starve_cnt also clears on any iBus grant and whenever ibus_cmd_valid is low.
//   - cmd_ready is high only for the granted bus; the grant is valid only with that bus's cmd_valid.
//   - Both buses idle: chipselect = 0.
//  Legality:
//   - In range: BASE_ADDR <= addr < BASE_ADDR + 4*2^ADDR_W.
//   - iBus requires addr[1:0] == 0.
//   - dBus: size 1 requires addr[0] == 0; size 2 requires addr[1:0] == 0; size 3 is always illegal.
//   - An illegal access is still accepted (ready = 1) with chipselect = 0, and it sets err_sticky.
//  Byteenable: size 0 -> 4'b0001 << addr[1:0]; size 1 -> 4'b0011 << {addr[1],1'b0}; size 2 and iBus -> 4'b1111.
//  BRAM drive: address, chipselect, write, byteenable and writedata are combinational from the grant in the accept cycle.
//  Reads:
//   - Every accepted fetch or load, legal or not, enters a READ_LATENCY-deep shift pipe of {valid, src, err}.
//   - The response asserts exactly READ_LATENCY cycles after accept, for one cycle, on the src bus.
//   - Data is onchip_memory_readdata, or 0 if err. Responses stay in order; the pipe never stalls (rsp has no ready).
//  Stores: single cycle with no response. A store followed by a load to the same word returns the new data.
//  Back-to-back: one accept per cycle sustained, and iBus and dBus responses may fall in consecutive cycles.
// STRUCTURE
//  Package vex_bram_pkg:
//   - src_e {SRC_IBUS, SRC_DBUS}
//   - SIZE_B/SIZE_H/SIZE_W localparams
//   - function be_gen(size, addr[1:0])
//   - rsp_tag_t struct {valid, src, err}
//  Sub-module vex_bram_rsp_pipe: parameterised READ_LATENCY shift register of rsp_tag_t with async reset.
// TESTING
//  1. Reset, then dBus load at 0x10 with BRAM word 4 = 0xCAFEBABE, READ_LATENCY = 1
//     -> address = 4; dbus_rsp_valid 1 cycle later; data 0xCAFEBABE; error 0.
//  2. Byte store size 0 at 0x13, data 0x11111111
//     -> byteenable 4'b1000, write = 1, no rsp; a word load at 0x10 then returns 0x11FEBABE.
//  3. Both valid every cycle, STARVE_LIMIT = 2
//     -> grant pattern D,D,I,D,D,I...; every iBus fetch gets an ibus_rsp after READ_LATENCY.
//  4. dBus load at BASE + 0x1000 (out of range)
//     -> chipselect 0; rsp error = 1, data 0; err_sticky = 1; also repeat for half access at 0x3.
//  5. READ_LATENCY = 2 with fetch, load, fetch on consecutive cycles
//     -> responses at +2, +3, +4 on the correct buses, in order.
//  6. Assert reset_reset_n low one cycle after a load accept
//     -> no dbus_rsp_valid ever appears; outputs at reset values immediately (async).

Source files
------------

// File: rtl/vex_bram_pkg.sv
// Shared types for the VexRiscv iBus/dBus to BRAM arbiter.
// Source tags, access sizes, lane-mask helper and response tags.
package vex_bram_pkg;

  typedef enum logic {
    SRC_IBUS = 1'b0,
    SRC_DBUS = 1'b1
  } src_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef struct packed {
    logic valid;
    src_e src;
    logic err;
  } rsp_tag_t;

  function automatic logic [3:0] be_gen(
    input logic [1:0] size,
    input logic [1:0] addr
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      size == SIZE_B: be = 4'b0001 << addr;
      size == SIZE_H: be = 4'b0011 << {addr[1], 1'b0};
      default:        be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/vex_bram_rsp_pipe.sv
// Fixed-depth shift pipe carrying read tags alongside BRAM latency.
// Never stalls; reset flushes every stage.
module vex_bram_rsp_pipe
  import vex_bram_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/vex_bram_bus_arbiter.sv
// Arbitrates VexRiscv iBus and dBus onto one BRAM port.
// dBus wins unless iBus has lost STARVE_LIMIT times in a row.
module vex_bram_bus_arbiter
  import vex_bram_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              ibus_cmd_valid,
  output logic              ibus_cmd_ready,
  input  logic [31:0]       ibus_cmd_pc,
  output logic              ibus_rsp_valid,
  output logic              ibus_rsp_error,
  output logic [31:0]       ibus_rsp_inst,
  input  logic              dbus_cmd_valid,
  output logic              dbus_cmd_ready,
  input  logic              dbus_cmd_wr,
  input  logic [31:0]       dbus_cmd_address,
  input  logic [31:0]       dbus_cmd_data,
  input  logic [1:0]        dbus_cmd_size,
  output logic              dbus_rsp_valid,
  output logic              dbus_rsp_error,
  output logic [31:0]       dbus_rsp_data,
  output logic [ADDR_W-1:0] onchip_memory_address,
  output logic              onchip_memory_chipselect,
  output logic              onchip_memory_clken,
  output logic              onchip_memory_write,
  output logic [31:0]       onchip_memory_writedata,
  output logic [3:0]        onchip_memory_byteenable,
  input  logic [31:0]       onchip_memory_readdata,
  output logic              err_sticky
);

  logic [2:0]  starve_q;
  logic        force_i;
  logic        grant_i;
  logic        grant_d;
  logic        acc;
  logic        acc_legal;
  logic [31:0] d_off;
  logic [31:0] i_off;
  logic        d_in;
  logic        i_in;
  logic        d_align;
  logic        d_legal;
  logic        i_legal;
  logic        clken_q;
  rsp_tag_t    tag_in;
  rsp_tag_t    tag_out;

  assign force_i = ibus_cmd_valid
                && (starve_q == 3'(STARVE_LIMIT));
  assign grant_d = reset_reset_n && dbus_cmd_valid
                && !force_i;
  assign grant_i = reset_reset_n && ibus_cmd_valid
                && !grant_d;
  assign acc     = grant_d || grant_i;

  assign d_off = dbus_cmd_address - BASE_ADDR;
  assign i_off = ibus_cmd_pc - BASE_ADDR;
  assign d_in  = (d_off >> (ADDR_W + 2)) == 32'd0;
  assign i_in  = (i_off >> (ADDR_W + 2)) == 32'd0;

  always_comb begin
    d_align = 1'b0;
    unique case (1'b1)
      dbus_cmd_size == SIZE_B: d_align = 1'b1;
      dbus_cmd_size == SIZE_H: d_align = !dbus_cmd_address[0];
      dbus_cmd_size == SIZE_W: d_align = dbus_cmd_address[1:0] == 2'b00;
      default:                 d_align = 1'b0;
    endcase
  end

  assign d_legal   = d_in && d_align;
  assign i_legal   = i_in && (ibus_cmd_pc[1:0] == 2'b00);
  assign acc_legal = grant_d ? d_legal : i_legal;

  assign ibus_cmd_ready = grant_i;
  assign dbus_cmd_ready = grant_d;

  assign onchip_memory_chipselect = acc && acc_legal;
  assign onchip_memory_write      = onchip_memory_chipselect
                                 && grant_d && dbus_cmd_wr;
  assign onchip_memory_writedata  = dbus_cmd_data;
  assign onchip_memory_clken      = clken_q;

  always_comb begin
    onchip_memory_address    = '0;
    onchip_memory_byteenable = 4'b0000;
    if (acc) begin
      onchip_memory_address = grant_d ? d_off[ADDR_W+1:2]
                                      : i_off[ADDR_W+1:2];
    end
    if (onchip_memory_chipselect) begin
      onchip_memory_byteenable = grant_d
        ? be_gen(dbus_cmd_size, dbus_cmd_address[1:0])
        : 4'b1111;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      starve_q   <= 3'd0;
      err_sticky <= 1'b0;
      clken_q    <= 1'b0;
    end else begin
      clken_q <= 1'b1;
      if (!ibus_cmd_valid || grant_i) begin
        starve_q <= 3'd0;
      end else if (grant_d) begin
        starve_q <= starve_q + 3'd1;
      end
      if (acc && !acc_legal) begin
        err_sticky <= 1'b1;
      end
    end
  end

  // Illegal reads still occupy a slot so responses stay in order.
  always_comb begin
    tag_in.valid = grant_i || (grant_d && !dbus_cmd_wr);
    tag_in.src   = grant_d ? SRC_DBUS : SRC_IBUS;
    tag_in.err   = !acc_legal;
  end

  vex_bram_rsp_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rsp_pipe (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign ibus_rsp_valid = tag_out.valid
                       && (tag_out.src == SRC_IBUS);
  assign dbus_rsp_valid = tag_out.valid
                       && (tag_out.src == SRC_DBUS);
  assign ibus_rsp_error = ibus_rsp_valid && tag_out.err;
  assign dbus_rsp_error = dbus_rsp_valid && tag_out.err;
  assign ibus_rsp_inst  = (ibus_rsp_valid && !tag_out.err)
                        ? onchip_memory_readdata : 32'd0;
  assign dbus_rsp_data  = (dbus_rsp_valid && !tag_out.err)
                        ? onchip_memory_readdata : 32'd0;

endmodule

// File: tb/tb_vex_bram_bus_arbiter.sv
// Bench for vex_bram_bus_arbiter: latency-1 and latency-2 instances
// with behavioural BRAMs and per-instance response scoreboards.
module tb_vex_bram_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          src;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1;
  exp_t e2;

  logic [31:0] ref_mem [1024];

  // instance 1 (READ_LATENCY = 1)
  logic iv1, ird1, irv1, ire1;
  logic [31:0] ipc1, iri1;
  logic dv1, drd1, dwr1, drv1, dre1;
  logic [31:0] dad1, ddat1, drdat1;
  logic [1:0] dsz1;
  logic [9:0] ma1;
  logic mcs1, mck1, mwr1, es1;
  logic [31:0] mwd1, mrd1;
  logic [3:0] mbe1;

  // instance 2 (READ_LATENCY = 2)
  logic iv2, ird2, irv2, ire2;
  logic [31:0] ipc2, iri2;
  logic dv2, drd2, dwr2, drv2, dre2;
  logic [31:0] dad2, ddat2, drdat2;
  logic [1:0] dsz2;
  logic [9:0] ma2;
  logic mcs2, mck2, mwr2, es2;
  logic [31:0] mwd2, mrd2;
  logic [3:0] mbe2;

  logic        pre_we;
  logic [9:0]  pre_a;
  logic [31:0] pre_d;

  vex_bram_bus_arbiter #(
    .READ_LATENCY (1)
  ) dut1 (
    .clk_clk                  (clk),
    .reset_reset_n            (rst_n),
    .ibus_cmd_valid           (iv1),
    .ibus_cmd_ready           (ird1),
    .ibus_cmd_pc              (ipc1),
    .ibus_rsp_valid           (irv1),
    .ibus_rsp_error           (ire1),
    .ibus_rsp_inst            (iri1),
    .dbus_cmd_valid           (dv1),
    .dbus_cmd_ready           (drd1),
    .dbus_cmd_wr              (dwr1),
    .dbus_cmd_address         (dad1),
    .dbus_cmd_data            (ddat1),
    .dbus_cmd_size            (dsz1),
    .dbus_rsp_valid           (drv1),
    .dbus_rsp_error           (dre1),
    .dbus_rsp_data            (drdat1),
    .onchip_memory_address    (ma1),
    .onchip_memory_chipselect (mcs1),
    .onchip_memory_clken      (mck1),
    .onchip_memory_write      (mwr1),
    .onchip_memory_writedata  (mwd1),
    .onchip_memory_byteenable (mbe1),
    .onchip_memory_readdata   (mrd1),
    .err_sticky               (es1)
  );

  vex_bram_bus_arbiter #(
    .READ_LATENCY (2)
  ) dut2 (
    .clk_clk                  (clk),
    .reset_reset_n            (rst_n),
    .ibus_cmd_valid           (iv2),
    .ibus_cmd_ready           (ird2),
    .ibus_cmd_pc              (ipc2),
    .ibus_rsp_valid           (irv2),
    .ibus_rsp_error           (ire2),
    .ibus_rsp_inst            (iri2),
    .dbus_cmd_valid           (dv2),
    .dbus_cmd_ready           (drd2),
    .dbus_cmd_wr              (dwr2),
    .dbus_cmd_address         (dad2),
    .dbus_cmd_data            (ddat2),
    .dbus_cmd_size            (dsz2),
    .dbus_rsp_valid           (drv2),
    .dbus_rsp_error           (dre2),
    .dbus_rsp_data            (drdat2),
    .onchip_memory_address    (ma2),
    .onchip_memory_chipselect (mcs2),
    .onchip_memory_clken      (mck2),
    .onchip_memory_write      (mwr2),
    .onchip_memory_writedata  (mwd2),
    .onchip_memory_byteenable (mbe2),
    .onchip_memory_readdata   (mrd2),
    .err_sticky               (es2)
  );

  logic [31:0] mem1 [1024];
  logic [31:0] mem2 [1024];
  logic [31:0] rd2a;

  always @(posedge clk) begin
    if (pre_we) begin
      mem1[pre_a] <= pre_d;
    end else if (mcs1 && mwr1) begin
      for (int b = 0; b < 4; b++)
        if (mbe1[b]) mem1[ma1][b*8+:8] <= mwd1[b*8+:8];
    end
    if (mcs1 && !mwr1) mrd1 <= mem1[ma1];
  end

  always @(posedge clk) begin
    if (pre_we) begin
      mem2[pre_a] <= pre_d;
    end else if (mcs2 && mwr2) begin
      for (int b = 0; b < 4; b++)
        if (mbe2[b]) mem2[ma2][b*8+:8] <= mwd2[b*8+:8];
    end
    if (mcs2 && !mwr2) rd2a <= mem2[ma2];
    mrd2 <= rd2a;
  end

  // scoreboard for instance 1
  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].due < cyc) begin
      total++;
      bad++;
      $display("FAIL rsp1_missing due=%0d now=%0d",
               q1[0].due, cyc);
      void'(q1.pop_front());
    end
    if (irv1 || drv1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL rsp1_unexpected i=%b d=%b cyc=%0d",
                 irv1, drv1, cyc);
      end else begin
        e1 = q1.pop_front();
        if ({irv1, drv1, drv1 ? dre1 : ire1,
             drv1 ? drdat1 : iri1, cyc} !==
            {!e1.src, e1.src, e1.err, e1.data, e1.due}) begin
          bad++;
          $display("FAIL rsp1 got i=%b d=%b e=%b %h @%0d exp src=%b e=%b %h @%0d",
                   irv1, drv1, drv1 ? dre1 : ire1,
                   drv1 ? drdat1 : iri1, cyc,
                   e1.src, e1.err, e1.data, e1.due);
        end
      end
    end
  end

  // scoreboard for instance 2
  always @(negedge clk) begin
    if (q2.size() > 0 && q2[0].due < cyc) begin
      total++;
      bad++;
      $display("FAIL rsp2_missing due=%0d now=%0d",
               q2[0].due, cyc);
      void'(q2.pop_front());
    end
    if (irv2 || drv2) begin
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL rsp2_unexpected i=%b d=%b cyc=%0d",
                 irv2, drv2, cyc);
      end else begin
        e2 = q2.pop_front();
        if ({irv2, drv2, drv2 ? dre2 : ire2,
             drv2 ? drdat2 : iri2, cyc} !==
            {!e2.src, e2.src, e2.err, e2.data, e2.due}) begin
          bad++;
          $display("FAIL rsp2 got i=%b d=%b e=%b %h @%0d exp src=%b e=%b %h @%0d",
                   irv2, drv2, drv2 ? dre2 : ire2,
                   drv2 ? drdat2 : iri2, cyc,
                   e2.src, e2.err, e2.data, e2.due);
        end
      end
    end
  end

  function automatic logic [3:0] ref_be(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    if (sz == 2'd0) return 4'b0001 << a;
    if (sz == 2'd1) return 4'b0011 << {a[1], 1'b0};
    return 4'b1111;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle1();
    tick();
    iv1 = 0; dv1 = 0; dwr1 = 0;
  endtask

  task automatic drv_d(input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz);
    tick();
    iv1 = 0; dv1 = 1; dwr1 = wr;
    dad1 = a; ddat1 = d; dsz1 = sz;
    #1;
  endtask

  task automatic ref_store(input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [1:0] sz);
    logic [3:0] be;
    be = ref_be(sz, a[1:0]);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a[11:2]][b*8+:8] = d[b*8+:8];
  endtask

  task automatic test_reset();
    rst_n = 0;
    iv1 = 0; ipc1 = 0; dv1 = 1; dwr1 = 1;
    dad1 = 32'h10; ddat1 = 32'hFFFF_FFFF; dsz1 = 2;
    iv2 = 0; ipc2 = 0; dv2 = 0; dwr2 = 0;
    dad2 = 0; ddat2 = 0; dsz2 = 2;
    pre_we = 0; pre_a = 0; pre_d = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      pre_we = 1;
      pre_a = (i < 16) ? 10'(i) : 10'd1023;
      pre_d = (i == 4) ? 32'hCAFE_BABE
                       : 32'h1000_0000 + i * 32'h0101_0101;
      ref_mem[pre_a] = pre_d;
    end
    tick();
    pre_we = 0;
    total++;
    if ({irv1, ire1, iri1, drv1, dre1, drdat1, mcs1, mwr1,
         mbe1, es1, ird1, drd1} !== '0) begin
      bad++;
      $display("FAIL reset_outs cs=%b wr=%b be=%b rv=%b%b es=%b rdy=%b%b",
               mcs1, mwr1, mbe1, irv1, drv1, es1, ird1, drd1);
    end
    dv1 = 0; dwr1 = 0;
    tick();
    rst_n = 1;
    tick();
    total++;
    if ({mck1, mck2, es1, es2} !== 4'b1100) begin
      bad++;
      $display("FAIL clken got=%b%b es=%b%b exp=11 00",
               mck1, mck2, es1, es2);
    end
  endtask

  task automatic test_load();
    drv_d(0, 32'h10, 0, 2);
    total++;
    if ({drd1, ird1, ma1, mcs1, mwr1, mbe1} !==
        {1'b1, 1'b0, 10'd4, 1'b1, 1'b0, 4'hF}) begin
      bad++;
      $display("FAIL load_cmd rdy=%b%b a=%0d cs=%b wr=%b be=%b",
               drd1, ird1, ma1, mcs1, mwr1, mbe1);
    end
    q1.push_back('{cyc + 1, 1'b1, 1'b0, 32'hCAFE_BABE});
    idle1();
    repeat (3) tick();
  endtask

  task automatic test_store();
    drv_d(1, 32'h13, 32'h1111_1111, 0);
    total++;
    if ({drd1, mcs1, mwr1, mbe1, ma1, mwd1} !==
        {1'b1, 1'b1, 1'b1, 4'b1000, 10'd4, 32'h1111_1111}) begin
      bad++;
      $display("FAIL store_b cs=%b wr=%b be=%b a=%0d wd=%h",
               mcs1, mwr1, mbe1, ma1, mwd1);
    end
    ref_store(32'h13, 32'h1111_1111, 0);
    drv_d(0, 32'h10, 0, 2);
    q1.push_back('{cyc + 1, 1'b1, 1'b0, 32'h11FE_BABE});
    drv_d(1, 32'h2, 32'h2222_2222, 1);
    total++;
    if ({mcs1, mwr1, mbe1, ma1} !==
        {1'b1, 1'b1, 4'b1100, 10'd0}) begin
      bad++;
      $display("FAIL store_h cs=%b wr=%b be=%b a=%0d",
               mcs1, mwr1, mbe1, ma1);
    end
    ref_store(32'h2, 32'h2222_2222, 1);
    drv_d(1, 32'h1, 32'h3333_3333, 0);
    total++;
    if ({mcs1, mwr1, mbe1} !== {1'b1, 1'b1, 4'b0010}) begin
      bad++;
      $display("FAIL store_b1 cs=%b wr=%b be=%b exp=1 1 0010",
               mcs1, mwr1, mbe1);
    end
    ref_store(32'h1, 32'h3333_3333, 0);
    drv_d(0, 32'h0, 0, 2);
    q1.push_back('{cyc + 1, 1'b1, 1'b0, ref_mem[0]});
    idle1();
    repeat (3) tick();
  endtask

  task automatic test_starve();
    logic [31:0] pc;
    logic [31:0] da;
    bit exp_i;
    pc = 0;
    idle1();
    for (int k = 0; k < 9; k++) begin
      tick();
      da = 32'h20 + 32'(4 * (k % 4));
      iv1 = 1; ipc1 = pc;
      dv1 = 1; dwr1 = 0; dad1 = da; dsz1 = 2;
      #1;
      exp_i = (k % 3 == 2);
      total++;
      if ({ird1, drd1} !== {exp_i, !exp_i}) begin
        bad++;
        $display("FAIL starve_grant k=%0d got i=%b d=%b exp i=%b",
                 k, ird1, drd1, exp_i);
      end
      if (exp_i) begin
        q1.push_back('{cyc + 1, 1'b0, 1'b0, ref_mem[pc[11:2]]});
        pc = pc + 4;
      end else begin
        q1.push_back('{cyc + 1, 1'b1, 1'b0, ref_mem[da[11:2]]});
      end
    end
    tick();
    dv1 = 0; iv1 = 1; ipc1 = 32'hC;
    #1;
    total++;
    if ({ird1, drd1, ma1} !== {1'b1, 1'b0, 10'd3}) begin
      bad++;
      $display("FAIL ibus_alone rdy=%b%b a=%0d", ird1, drd1, ma1);
    end
    q1.push_back('{cyc + 1, 1'b0, 1'b0, ref_mem[3]});
    idle1();
    repeat (3) tick();
  endtask

  task automatic test_range();
    drv_d(0, 32'h1000, 0, 2);
    total++;
    if ({drd1, mcs1, mwr1, mbe1} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
      bad++;
      $display("FAIL oor_load rdy=%b cs=%b wr=%b be=%b",
               drd1, mcs1, mwr1, mbe1);
    end
    q1.push_back('{cyc + 1, 1'b1, 1'b1, 32'd0});
    idle1();
    total++;
    if (es1 !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky got=%b exp=1", es1);
    end
    drv_d(0, 32'h3, 0, 1);
    total++;
    if ({drd1, mcs1} !== 2'b10) begin
      bad++;
      $display("FAIL misaligned_h rdy=%b cs=%b", drd1, mcs1);
    end
    q1.push_back('{cyc + 1, 1'b1, 1'b1, 32'd0});
    drv_d(1, 32'h0, 32'hDEAD_BEEF, 3);
    total++;
    if ({drd1, mcs1, mwr1} !== 3'b100) begin
      bad++;
      $display("FAIL size3_store rdy=%b cs=%b wr=%b",
               drd1, mcs1, mwr1);
    end
    tick();
    dv1 = 0; iv1 = 1; ipc1 = 32'h2;
    #1;
    total++;
    if ({ird1, mcs1} !== 2'b10) begin
      bad++;
      $display("FAIL ibus_misaligned rdy=%b cs=%b", ird1, mcs1);
    end
    q1.push_back('{cyc + 1, 1'b0, 1'b1, 32'd0});
    tick();
    ipc1 = 32'hFFC;
    #1;
    total++;
    if ({ird1, mcs1, ma1, mbe1} !==
        {1'b1, 1'b1, 10'd1023, 4'hF}) begin
      bad++;
      $display("FAIL ibus_top rdy=%b cs=%b a=%0d be=%b",
               ird1, mcs1, ma1, mbe1);
    end
    q1.push_back('{cyc + 1, 1'b0, 1'b0, ref_mem[1023]});
    tick();
    ipc1 = 32'h1000;
    #1;
    q1.push_back('{cyc + 1, 1'b0, 1'b1, 32'd0});
    idle1();
    repeat (3) tick();
    total++;
    if (es1 !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky_hold got=%b exp=1", es1);
    end
  endtask

  task automatic test_lat2();
    tick();
    iv2 = 1; ipc2 = 32'h8;
    #1;
    total++;
    if (ird2 !== 1'b1) begin
      bad++;
      $display("FAIL lat2_f0 rdy got=%b exp=1", ird2);
    end
    q2.push_back('{cyc + 2, 1'b0, 1'b0, ref_mem[2]});
    tick();
    iv2 = 0; dv2 = 1; dwr2 = 0; dad2 = 32'h14; dsz2 = 2;
    #1;
    total++;
    if ({drd2, ma2} !== {1'b1, 10'd5}) begin
      bad++;
      $display("FAIL lat2_ld rdy=%b a=%0d", drd2, ma2);
    end
    q2.push_back('{cyc + 2, 1'b1, 1'b0, ref_mem[5]});
    tick();
    dv2 = 0; iv2 = 1; ipc2 = 32'hC;
    #1;
    q2.push_back('{cyc + 2, 1'b0, 1'b0, ref_mem[3]});
    tick();
    iv2 = 0;
    repeat (5) tick();
  endtask

  task automatic test_reset_mid();
    tick();
    dv2 = 1; dwr2 = 0; dad2 = 32'h14; dsz2 = 2;
    #1;
    total++;
    if (drd2 !== 1'b1) begin
      bad++;
      $display("FAIL mid_accept rdy got=%b exp=1", drd2);
    end
    tick();
    rst_n = 0;
    #1;
    total++;
    if ({drv2, irv2, mcs2, mwr2, mbe2, drd2, es1} !== '0) begin
      bad++;
      $display("FAIL mid_reset rv=%b%b cs=%b wr=%b be=%b rdy=%b es=%b",
               drv2, irv2, mcs2, mwr2, mbe2, drd2, es1);
    end
    tick();
    dv2 = 0;
    tick();
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (drv2 !== 1'b0) begin
        bad++;
        $display("FAIL mid_dropped k=%0d rsp got=%b exp=0", k, drv2);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_starve();
    test_range();
    test_lat2();
    test_reset_mid();
    repeat (3) tick();
    total++;
    if ((q1.size() + q2.size()) !== 0) begin
      bad++;
      $display("FAIL drain pending got=%0d exp=0",
               q1.size() + q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
